// File: rtl/frame_writer_pkg.sv
// Shared types and rotation constants for the frame writer.
// The rotation table gives start address and the two address steps.
package frame_writer_pkg;

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] pix_step;
        logic [31:0] line_step;
    } rot_cfg_t;

    // Negative steps are two's complement; the consumer truncates them.
    function automatic rot_cfg_t rot_cfg(rot_t rot, int unsigned w,
                                         int unsigned h);
        rot_cfg_t c;
        c = '0;
        unique case (rot)
            ROT_0: begin
                c.start     = 32'd0;
                c.pix_step  = 32'd1;
                c.line_step = w;
            end
            ROT_90: begin
                c.start     = h - 32'd1;
                c.pix_step  = h;
                c.line_step = 32'hFFFF_FFFF;
            end
            ROT_180: begin
                c.start     = w * h - 32'd1;
                c.pix_step  = 32'hFFFF_FFFF;
                c.line_step = 32'd0 - w;
            end
            ROT_270: begin
                c.start     = (w - 32'd1) * h;
                c.pix_step  = 32'd0 - h;
                c.line_step = 32'd1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rot_addr_gen.sv
// Incremental rotated write-address generator (add/subtract only).
// addr is the address of the pixel being accepted this cycle.
module rot_addr_gen
    import frame_writer_pkg::*;
#(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned ADDR_SZ = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               pix_adv,
    input  logic               line_adv,
    input  rot_t               rot,
    output logic [ADDR_SZ-1:0] addr
);

    rot_cfg_t cfg;
    logic [ADDR_SZ-1:0] line_base;
    logic [ADDR_SZ-1:0] addr_q;
    logic [ADDR_SZ-1:0] pix_step;
    logic [ADDR_SZ-1:0] line_step;
    logic [ADDR_SZ-1:0] base_now;
    logic [ADDR_SZ-1:0] ps_now;
    logic [ADDR_SZ-1:0] ls_now;
    logic unused_hi;

    assign cfg = rot_cfg(rot, IMG_W, IMG_H);
    assign unused_hi = ^{cfg.start[31:ADDR_SZ], cfg.pix_step[31:ADDR_SZ],
                         cfg.line_step[31:ADDR_SZ]};

    // A load makes the current pixel (0,0) of the new rotation.
    always_comb begin
        base_now = load ? cfg.start[ADDR_SZ-1:0] : line_base;
        addr     = load ? cfg.start[ADDR_SZ-1:0] : addr_q;
        ps_now   = load ? cfg.pix_step[ADDR_SZ-1:0] : pix_step;
        ls_now   = load ? cfg.line_step[ADDR_SZ-1:0] : line_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            addr_q    <= '0;
            pix_step  <= '0;
            line_step <= '0;
        end else begin
            if (load) begin
                pix_step  <= cfg.pix_step[ADDR_SZ-1:0];
                line_step <= cfg.line_step[ADDR_SZ-1:0];
                line_base <= base_now;
                addr_q    <= base_now;
            end
            if (line_adv) begin
                line_base <= base_now + ls_now;
                addr_q    <= base_now + ls_now;
            end else if (pix_adv) begin
                addr_q <= addr + ps_now;
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Writes a start/data/jump pixel stream into frame RAM with rotation,
// reporting frame completion and sticky stream-format errors.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned ADDR_SZ   = 20,
    parameter int unsigned RAM_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [23:0]          data_in,
    input  logic                 jump_in,
    input  logic [1:0]           rot_in,
    output logic                 ram_we,
    output logic [ADDR_SZ-1:0]   ram_addr,
    output logic [RAM_WIDTH-1:0] ram_wdata,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    state_t state, state_nx;
    logic [XW-1:0] x, cur_x;
    logic [YW-1:0] y, cur_y;
    logic accept, x_end, eol, last, fmt_err, err_nx;
    logic [ADDR_SZ-1:0] addr;

    rot_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_SZ(ADDR_SZ)
    ) u_addr (
        .clk     (clk_in),
        .rst     (rst_in),
        .load    (start_in),
        .pix_adv (accept && !eol),
        .line_adv(accept && eol),
        .rot     (rot_t'(rot_in)),
        .addr    (addr)
    );

    assign busy = (state == ACTIVE);

    // start_in always begins a frame at (0,0), whatever the state.
    always_comb begin
        accept   = start_in || (state == ACTIVE);
        cur_x    = start_in ? '0 : x;
        cur_y    = start_in ? '0 : y;
        x_end    = (cur_x == XW'(IMG_W - 1));
        eol      = jump_in || x_end;
        last     = eol && (cur_y == YW'(IMG_H - 1));
        fmt_err  = accept && (jump_in != x_end);
        err_nx   = start_in ? ((state == ACTIVE) || fmt_err)
                            : (err || fmt_err);
        state_nx = IDLE;
        if (accept)
            state_nx = last ? DONE : ACTIVE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            err        <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            err        <= err_nx;
            ram_we     <= accept;
            ram_addr   <= addr;
            ram_wdata  <= RAM_WIDTH'(data_in);
            frame_done <= (state == DONE);
            if (accept) begin
                if (eol) begin
                    x <= '0;
                    y <= cur_y + YW'(1);
                end else begin
                    x <= cur_x + XW'(1);
                    y <= cur_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: tabled rotation frames,
// hand-written corner sequences and random streams vs a coordinate model.
module tb_frame_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 20;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic [23:0]   data_in = '0;
    logic          jump_in = 1'b0;
    logic [1:0]    rot_in = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          busy;
    logic          frame_done;
    logic          err;

    frame_writer #(
        .IMG_W    (W),
        .IMG_H    (H),
        .ADDR_SZ  (AW),
        .RAM_WIDTH(32)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .data_in   (data_in),
        .jump_in   (jump_in),
        .rot_in    (rot_in),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: frame position in pixel coordinates.
    bit         m_active, m_err, m_last;
    int         m_x, m_y;
    logic [1:0] m_rot;
    bit            e_we, e_busy, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;

    typedef struct packed {
        logic [1:0]  rot;
        logic [47:0] addrs;
    } vec_t;

    vec_t tab [4];

    function automatic logic [AW-1:0] addr_of(int r, int x, int y);
        int a;
        case (r)
            0:       a = y * W + x;
            1:       a = x * H + (H - 1 - y);
            2:       a = W * H - 1 - (y * W + x);
            default: a = (W - 1 - x) * H + y;
        endcase
        return AW'(a);
    endfunction

    task automatic model_clear();
        m_active = 0; m_err = 0; m_last = 0;
        m_x = 0; m_y = 0; m_rot = 0;
        e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
        e_addr = '0; e_wdata = '0;
    endtask

    task automatic model(bit s, bit j, logic [1:0] r, logic [23:0] d);
        bit acc, eol, lst, bad;
        int cx, cy;
        logic [1:0] rr;
        acc = s || m_active;
        cx  = s ? 0 : m_x;
        cy  = s ? 0 : m_y;
        rr  = s ? r : m_rot;
        e_we    = acc;
        e_addr  = addr_of(int'(rr), cx, cy);
        e_wdata = {8'h00, d};
        e_done  = m_last;
        eol = j || (cx == W - 1);
        lst = acc && eol && (cy == H - 1);
        bad = acc && (j != (cx == W - 1));
        if (s)
            m_err = m_active || bad;
        else
            m_err = m_err || bad;
        e_err = m_err;
        if (acc) begin
            m_rot = rr;
            if (eol) begin m_x = 0; m_y = cy + 1; end
            else begin m_x = cx + 1; m_y = cy; end
            m_active = !lst;
        end
        e_busy = m_active;
        m_last = lst;
    endtask

    task automatic check_out(string tag);
        n_vec++;
        if (ram_we !== e_we || busy !== e_busy || frame_done !== e_done ||
            err !== e_err ||
            (e_we && (ram_addr !== e_addr || ram_wdata !== e_wdata))) begin
            n_bad++;
            $display("FAIL %s: got we=%b addr=%0d wd=%h busy=%b done=%b err=%b want we=%b addr=%0d wd=%h busy=%b done=%b err=%b",
                     tag, ram_we, ram_addr, ram_wdata, busy, frame_done, err,
                     e_we, e_addr, e_wdata, e_busy, e_done, e_err);
        end
    endtask

    task automatic expect_addr(string tag, logic [AW-1:0] a);
        n_vec++;
        if (ram_we !== 1'b1 || ram_addr !== a) begin
            n_bad++;
            $display("FAIL %s: got we=%b addr=%0d want we=1 addr=%0d",
                     tag, ram_we, ram_addr, a);
        end
    endtask

    task automatic expect_bit(string tag, logic act, logic want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, act, want);
        end
    endtask

    task automatic step(bit s, bit j, logic [1:0] r, logic [23:0] d,
                        string tag);
        @(negedge clk_in);
        start_in = s; jump_in = j; rot_in = r; data_in = d;
        model(s, j, r, d);
        @(posedge clk_in);
        #1;
        check_out(tag);
    endtask

    task automatic run_frame(logic [1:0] r, int first, bit chk,
                             logic [47:0] addrs, string tag);
        logic [47:0] t;
        t = addrs;
        for (int i = first; i < W * H; i++) begin
            step(i == 0, (i % W) == W - 1, r,
                 {8'(i), 6'd0, r, 8'h5A}, tag);
            if (chk) expect_addr(tag, AW'(t[i*4 +: 4]));
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #1;
        model_clear();
        check_out("reset");
        expect_bit("reset_addr", |ram_addr, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        bit s, j;
        int cx;
        logic [1:0] r;
        tab[0] = '{rot: 2'd0, addrs: 48'hBA9876543210};
        tab[1] = '{rot: 2'd1, addrs: 48'h9630A741B852};
        tab[2] = '{rot: 2'd2, addrs: 48'h0123456789AB};
        tab[3] = '{rot: 2'd3, addrs: 48'h258B147A0369};
        model_clear();
        do_reset();

        for (int k = 0; k < 4; k++) begin
            run_frame(tab[k].rot, 0, 1'b1, tab[k].addrs, "rot_frame");
            step(0, 0, 0, 24'h0, "rot_done");
            expect_bit("frame_done", frame_done, 1'b1);
            expect_bit("frame_err", err, 1'b0);
        end

        // Short first line: jump at x=1.
        step(1, 0, 0, 24'h000111, "short");
        step(0, 1, 0, 24'h000222, "short");
        expect_bit("short_err", err, 1'b1);
        step(0, 0, 0, 24'h000333, "short");
        expect_addr("short_next", AW'(4));
        for (int i = 1; i < 2 * W; i++)
            step(0, (i % W) == W - 1, 0, 24'(i), "short");
        step(0, 0, 0, 24'h0, "short_done");
        expect_bit("short_done", frame_done, 1'b1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 5; i++)
            step(i == 0, (i % W) == W - 1, 0, 24'(i + 7), "prerst");
        @(negedge clk_in);
        #2;
        do_reset();
        step(0, 0, 0, 24'h0, "post_rst");
        run_frame(2'd0, 0, 1'b1, tab[0].addrs, "clean");
        step(0, 0, 0, 24'h0, "clean_done");
        expect_bit("clean_err", err, 1'b0);

        // Restart at pixel 6 with rot 1, then a back-to-back frame.
        for (int i = 0; i < 6; i++)
            step(i == 0, (i % W) == W - 1, 0, 24'(i), "prestart");
        step(1, 0, 1, 24'hABCDEF, "restart");
        expect_addr("restart_addr", AW'(2));
        expect_bit("restart_err", err, 1'b1);
        run_frame(2'd1, 1, 1'b1, tab[1].addrs, "restart_frame");
        run_frame(2'd2, 0, 1'b1, tab[2].addrs, "b2b");
        step(0, 0, 0, 24'h0, "b2b_done");
        expect_bit("b2b_done", frame_done, 1'b1);

        // Random streams with occasional format errors and restarts.
        for (int c = 0; c < 800; c++) begin
            if (!m_active) s = ($urandom_range(2) == 0);
            else s = ($urandom_range(40) == 0);
            cx = s ? 0 : m_x;
            j = (cx == W - 1);
            if ($urandom_range(12) == 0) j = !j;
            r = 2'($urandom_range(3));
            step(s, j, r, 24'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Downstream of the pixel-stream adapter. Consumes its start/data/jump stream of 24-bit RGB pixels and writes each pixel into the 32-bit-wide frame RAM.
- Write addresses are generated so the stored frame is rotated by 0/90/180/270 degrees.
- Address generation is incremental (add/subtract only, no multiplier).
- Signals frame completion and sticky stream-format errors to the controller.

Parameters:
IMG_W, 640, source image width in pixels (line length)
IMG_H, 480, source image height in lines; IMG_W*IMG_H must be at most 2**ADDR_SZ
ADDR_SZ, 20, RAM address width
RAM_WIDTH, 32, RAM data width

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  first pixel of frame present on data_in this cycle
data_in  input  24  RGB pixel {R,G,B}, valid every cycle while frame active
jump_in  input  1  this pixel is last of its line
rot_in  input  2  rotation: 0=0°, 1=90° CW, 2=180°, 3=270° CW; sampled only on start_in
ram_we  output  1  RAM write strobe
ram_addr  output  ADDR_SZ  RAM write address
ram_wdata  output  RAM_WIDTH  {8'h00, data} written pixel
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after last pixel written
err  output  1  sticky format error; cleared by next start_in or reset

Behaviour:
- Reset (async, rst_in=1): all outputs 0, FSM to IDLE, counters and address registers 0. Asserting reset mid-frame abandons the frame; no frame_done.
- Pixel coordinates: x in 0..IMG_W-1, y in 0..IMG_H-1, raster order.
- Destination address per rotation:
  - rot 0: y*W+x
  - rot 1: x*H+(H-1-y)
  - rot 2: W*H-1-(y*W+x)
  - rot 3: (W-1-x)*H+y
- Incremental registers: addr, line_base. Constants, latched with rot at start:
  - rot 0: start 0, pixel step +1, line step +W
  - rot 1: start H-1, pixel step +H, line step -1
  - rot 2: start W*H-1, pixel step -1, line step -W
  - rot 3: start (W-1)*H, pixel step -H, line step +1
- All arithmetic is modulo 2**ADDR_SZ.
- FSM states:
  - IDLE: busy=0. On start_in: latch rot, accept the pixel at the start address, x=0, y=0, clear err, go to ACTIVE.
  - ACTIVE: busy=1. Every cycle accepts one pixel at current addr. Next pixel uses addr+pixel step unless this is an end of line; then line_base += line step, addr = new line_base, x=0, y++.
  - DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE. start_in in DONE is treated as in IDLE, so back-to-back frames lose no pixels.
- End of line: jump_in=1 or x=W-1.
  - jump_in with x≠W-1 (short line): set err, advance line.
  - x=W-1 without jump_in (missing jump): set err, advance line.
- Last pixel: accepted at x=W-1, y=H-1 (or an end-of-line at y=H-1); go to DONE.
- start_in during ACTIVE: set err, restart the frame with this pixel as (0,0) using the newly sampled rot. err stays set for that frame.
- Latency: one registered stage. A pixel accepted in cycle n gives ram_we=1 with its ram_addr/ram_wdata in cycle n+1. frame_done is asserted in the cycle after the last ram_we. ram_we=0 whenever no pixel was accepted the previous cycle.

Decomposition:
- Package frame_writer_pkg holds:
  - rotation enum (ROT_0, ROT_90, ROT_180, ROT_270)
  - FSM state enum (IDLE, ACTIVE, DONE)
  - localparam function computing start/pixel-step/line-step from rot, IMG_W, IMG_H
- One sub-module, rot_addr_gen: holds addr/line_base and the step constants. Inputs: load, pix_adv, line_adv, rot. Output: addr.
- FSM, counters, error logic and output register stay in frame_writer.

Test Plan:
1. W=4,H=3, rot 0, 12 well-formed pixels with jump on x=3 -> ram_addr 0..11 in order, wdata {00,pixel}, frame_done one cycle after 12th write, err=0.
2. Same stream, rot 1 -> addresses 2,5,8,11, 1,4,7,10, 0,3,6,9.
3. rot 2 -> addresses 11 down to 0. rot 3 -> 9,6,3,0, 10,7,4,1, 11,8,5,2.
4. rot 0, jump_in at x=1 of line 0 -> err=1, next pixel written at addr 4; frame ends after line 2 with frame_done.
5. rst_in pulsed after 5 pixels -> outputs 0 immediately (async), no frame_done. A following clean frame writes 0..11 with err=0.
6. start_in re-asserted at pixel 6 (rot 1) -> err=1, address sequence restarts at 2. Back-to-back frame (start_in in DONE cycle) -> all 12 writes of the second frame present.
